// File: rtl/sbox_full_lut.sv
// sbox_full_lut: AES byte substitution as two full 256-entry constant tables.
// The forward table is SubBytes and the inverse table is InvSubBytes.
// `encrypt` selects which table output reaches byte_out.
//
// Build option: define SBOX_OUTPUT_REG_EN to register byte_out.
//   - Registered build: one cycle of latency, synchronous active-low reset to 0x00.
//   - Default build (macro undefined): a purely combinational lookup, and
//     clk/rst_n stay on the port list but are ignored.
module sbox_full_lut (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       encrypt,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    localparam logic [7:0] FWD_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_TABLE [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [7:0] w_fwdByte;
    logic [7:0] w_invByte;
    logic [7:0] w_lookup;

    // Both tables are always read.
    // The direction bit only steers the final mux, so an encrypt change has
    // the same latency as a byte_in change.
    always_comb begin
        w_fwdByte = FWD_TABLE[byte_in];
        w_invByte = INV_TABLE[byte_in];
        w_lookup  = encrypt ? w_fwdByte : w_invByte;
    end

`ifdef SBOX_OUTPUT_REG_EN
    logic [7:0] r_byteOut;

    // Load the lookup every cycle; a low rst_n wins and clears the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byteOut <= 8'h00;
        end else begin
            r_byteOut <= w_lookup;
        end
    end

    assign byte_out = r_byteOut;
`else
    logic w_unusedCtrl;

    // clk and rst_n are kept only so both builds share one port list.
    assign w_unusedCtrl = clk ^ rst_n;
    assign byte_out     = w_lookup;
`endif

endmodule

// File: tb/tb_sbox_full_lut.sv
// tb_sbox_full_lut: scoreboard bench for sbox_full_lut.
// Expected bytes come from two sources:
//   - hand-written FIPS-197 vectors;
//   - a GF(2^8) inverse + affine reference model computed inside the bench.
// Works for both builds (SBOX_OUTPUT_REG_EN defined or not).
module tb_sbox_full_lut;

`ifdef SBOX_OUTPUT_REG_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic       enc;
        logic [7:0] din;
        logic [7:0] want;
    } expEntry_t;

    typedef struct {
        logic       enc;
        logic [7:0] din;
        logic [7:0] want;
    } vector_t;

    logic       clk;
    logic       rst_n;
    logic       encrypt;
    logic [7:0] byte_in;
    logic [7:0] byte_out;

    expEntry_t  expQ[$];
    event       sampleEv;
    int         vectorCount;
    int         missCount;
    logic [7:0] fwdModel [0:255];
    logic [7:0] invModel [0:255];

    sbox_full_lut dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .encrypt  (encrypt),
        .byte_in  (byte_in),
        .byte_out (byte_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        prod = 8'h00;
        aa   = a;
        bb   = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) prod = prod ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return prod;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] dbl;
        dbl = {v, v} << n;
        return dbl[15:8];
    endfunction

    // Build reference tables from field arithmetic, independent of the RTL tables.
    task automatic buildModel();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            fwdModel[x] = s;
            invModel[s] = 8'(x);
        end
    endtask

    // Drive one input pair at a falling edge, record what must come out, and
    // signal the monitor once the DUT should be presenting that result.
    task automatic applyStimulus(input string tag, input logic rstVal, input logic enc,
                                 input logic [7:0] din, input logic [7:0] want);
        expEntry_t e;
        @(negedge clk);
        rst_n   = rstVal;
        encrypt = enc;
        byte_in = din;
        e.tag  = tag;
        e.enc  = enc;
        e.din  = din;
        e.want = want;
        expQ.push_back(e);
        if (REG_BUILD) begin
            @(posedge clk);
        end
        #1;
        ->sampleEv;
    endtask

    task automatic checkOutput();
        expEntry_t e;
        if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL unexpected_output got=%h want=<no entry queued>", byte_out);
        end else begin
            e = expQ.pop_front();
            vectorCount++;
            if (byte_out !== e.want) begin
                missCount++;
                $display("[TB] FAIL %s enc=%b in=%h got=%h want=%h", e.tag, e.enc, e.din, byte_out, e.want);
            end
        end
    endtask

    // Monitor: compares whenever the driver says an output is presented.
    initial begin
        forever begin
            @(sampleEv);
            checkOutput();
        end
    end

    initial begin
        vector_t dirVecs[$];
        logic [7:0] rstWant;

        vectorCount = 0;
        missCount   = 0;
        rst_n       = 1'b0;
        encrypt     = 1'b1;
        byte_in     = 8'h00;
        buildModel();

        // Reset: two edges with rst_n low, then release, then a mid-stream reassert.
        rstWant = REG_BUILD ? 8'h00 : 8'h63;
        applyStimulus("reset_hold1", 1'b0, 1'b1, 8'h00, rstWant);
        applyStimulus("reset_hold2", 1'b0, 1'b1, 8'h00, rstWant);
        applyStimulus("reset_release", 1'b1, 1'b1, 8'h00, 8'h63);
        applyStimulus("pre_reassert", 1'b1, 1'b1, 8'h53, 8'hed);
        applyStimulus("reassert", 1'b0, 1'b1, 8'hff, REG_BUILD ? 8'h00 : 8'h16);
        applyStimulus("after_reassert", 1'b1, 1'b1, 8'hff, 8'h16);

        // Hand-computed FIPS-197 vectors, including the boundary bytes.
        dirVecs = '{
            '{1'b1, 8'h00, 8'h63}, '{1'b1, 8'h01, 8'h7c}, '{1'b1, 8'h10, 8'hca},
            '{1'b1, 8'h53, 8'hed}, '{1'b1, 8'hff, 8'h16}, '{1'b1, 8'h80, 8'hcd},
            '{1'b0, 8'h00, 8'h52}, '{1'b0, 8'h01, 8'h09}, '{1'b0, 8'h63, 8'h00},
            '{1'b0, 8'hed, 8'h53}, '{1'b0, 8'hff, 8'h7d}, '{1'b0, 8'h7c, 8'h01}
        };
        foreach (dirVecs[i]) begin
            applyStimulus("directed", 1'b1, dirVecs[i].enc, dirVecs[i].din, dirVecs[i].want);
        end

        // Direction toggle with byte_in held at 0x53.
        applyStimulus("toggle_fwd", 1'b1, 1'b1, 8'h53, 8'hed);
        applyStimulus("toggle_inv", 1'b1, 1'b0, 8'h53, 8'h50);
        applyStimulus("toggle_fwd2", 1'b1, 1'b1, 8'h53, 8'hed);

        // Exhaustive sweeps against the field-arithmetic model.
        for (int x = 0; x < 256; x++) begin
            applyStimulus("fwd_sweep", 1'b1, 1'b1, 8'(x), fwdModel[x]);
        end
        for (int x = 0; x < 256; x++) begin
            applyStimulus("inv_sweep", 1'b1, 1'b0, 8'(x), invModel[x]);
        end

        // Round trip: the inverse applied to S(x) must return x.
        for (int x = 0; x < 256; x++) begin
            applyStimulus("round_trip", 1'b1, 1'b0, fwdModel[x], 8'(x));
        end

        @(negedge clk);
        @(negedge clk);
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard_drain got=%0d pending want=0 pending", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
